loproc_shifter_pipe: RTL
========================

// Module: loproc_shifter_pipe
// PURPOSE
//  Parametrised, pipelined successor to the 32-bit combinational shifter in the LoPROC datapath.
//  Performs logical/arithmetic shifts and rotates over DATA_W bits, split into PIPE_STAGES register stages.
//  Uses valid/ready handshakes on both sides, so the execute stage can stall it.
//  Also produces carry-out and zero flags for the status register.
// PARAMETERS
//  DATA_W       32  operand width; power of two, >= 8
//  SHAMT_W      5   shift-amount width = log2(DATA_W)
//  PIPE_STAGES  2   register stages, 1..SHAMT_W; equals the latency in cycles
// PORTS
//  clk        in   1        clock; every register updates on rising edge
//  rstn       in   1        synchronous reset, active low
//  in_valid   in   1        operand/op valid
//  in_ready   out  1        block accepts an operand this cycle
//  in_data    in   DATA_W   operand
//  in_shamt   in   SHAMT_W  shift amount, 0..DATA_W-1
//  in_op      in   3        `SHOP_LSL=0, `SHOP_LSR=1, `SHOP_ASR=2, `SHOP_ROL=3, `SHOP_ROR=4
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts the result
//  out_data   out  DATA_W   result
//  out_carry  out  1        last bit shifted out (rules below)
//  out_zero   out  1        out_data == 0
// BEHAVIOUR
//  - Reset: clk edge with rstn=0 clears every stage valid bit, out_data, out_carry and out_zero to 0.
//    In-flight operations are discarded. in_ready=0 while rstn=0.
//  - Transfer rule: a beat moves when valid && ready are both high on a rising edge.
//  - Pipeline advance: stage i advances when !valid_i || ready_(i+1); ready of the last stage is out_ready.
//    in_ready = !valid_0 || ready_1, a combinational chain with no bubbles.
//    Full throughput is 1 op/cycle; latency is exactly PIPE_STAGES cycles with no stall.
//  - Ordering and stalls: results leave in issue order.
//    A stalled stage holds its data, op, shamt remainder and carry unchanged.
//    out_* stays stable while out_valid && !out_ready.
//  - Shift levels: level j shifts by 2^j when in_shamt[j]=1.
//    Levels are distributed LSB-first over the stages. The first (SHAMT_W mod PIPE_STAGES) stages
//    take ceil(SHAMT_W/PIPE_STAGES) levels; the rest take floor(SHAMT_W/PIPE_STAGES).
//  - Ops:
//    LSL fills with 0. LSR fills with 0. ASR fills with the original in_data[DATA_W-1].
//    ROL/ROR wrap bits around.
//  - Carry:
//    LSL: carry = original bit DATA_W-s. LSR/ASR: carry = original bit s-1.
//    ROL: carry = out_data[0]. ROR: carry = out_data[DATA_W-1].
//    Carry is tracked per level: an active level overwrites it with its own last dropped bit.
//  - s=0: out_data = in_data and out_carry = 0 for every op.
//  - Undefined op codes 5..7 produce out_data = in_data, carry 0; they are still handshaked.
//  - out_zero is registered together with out_data in the final stage.
// STRUCTURE
//  - `SHOP_* codes and `DATA_W/`DATA_LOG2 defaults go in loproc_defines.vh.
//  - Sub-module loproc_shift_level: one combinational 2^j level.
//    Inputs: data, carry, op, enable, sign. Outputs: data, carry.
//  - Top level: per-stage registers (valid, data, op, remaining shamt bits, sign, carry) plus the handshake chain.
// TESTING (DATA_W=32, PIPE_STAGES=2, out_ready=1 unless stated)
//  1. in_data=0x89AA_1627, shamt=3, op=LSL -> 2 cycles later out_data=0x4D50_B138, carry=0, zero=0.
//  2. Same operand, shamt=3:
//     LSR -> 0x1135_42C4 c=1; ASR -> 0xF135_42C4 c=1; ROL -> 0x4D50_B13C c=0; ROR -> 0xF135_42C4 c=1.
//     Issue all four back-to-back: results appear on 4 consecutive cycles, in order.
//  3. Boundaries:
//     shamt=0, op=ASR -> 0x89AA_1627, c=0.
//     shamt=31, op=ASR -> 0xFFFF_FFFF, c=0.
//     shamt=31, op=LSL on 0x0000_0001 -> 0x8000_0000.
//     0x0000_0001 LSR 1 -> 0x0, zero=1, c=1.
//  4. Backpressure: issue 3 ops with out_ready=0 -> in_ready drops after 2 accepted and out_data holds stable.
//     Then raise out_ready -> all 3 emerge in order, none lost or duplicated.
//  5. Reset mid-stream: 2 ops in flight, rstn=0 for 1 edge -> out_valid=0 and out_data=0 next cycle.
//     No stale result ever appears; the first op after reset has normal latency.
//  6. Random scoreboard: 10k ops with random valid/ready against a reference model;
//     also sweep PIPE_STAGES=1 and 5.

Source files
------------

// File: rtl/loproc_shifter_pipe_pkg.sv
// Shared op codes, default widths and the level-to-stage distribution helpers
// for the pipelined LoPROC shifter.
package loproc_shifter_pipe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DATA_LOG2_DEF = 5;

  typedef enum logic [2:0] {
    SHOP_LSL = 3'd0,
    SHOP_LSR = 3'd1,
    SHOP_ASR = 3'd2,
    SHOP_ROL = 3'd3,
    SHOP_ROR = 3'd4
  } shop_e;

  // The first (sw % ps) stages carry one extra level; levels are assigned LSB-first.
  function automatic int lvl_count(input int stage, input int sw, input int ps);
    return (sw / ps) + ((stage < (sw % ps)) ? 1 : 0);
  endfunction

  function automatic int lvl_first(input int stage, input int sw, input int ps);
    return stage * (sw / ps) + ((stage < (sw % ps)) ? stage : (sw % ps));
  endfunction

  function automatic int stage_of(input int lvl, input int sw, input int ps);
    int stg;
    stg = 0;
    for (int g = 0; g < ps; g++) begin
      if (lvl >= lvl_first(g, sw, ps)) stg = g;
    end
    return stg;
  endfunction

endpackage

// File: rtl/loproc_shift_level.sv
// One combinational shift level of fixed distance SHIFT (a power of two).
// When enabled it shifts/rotates and replaces the carry with its last dropped bit.
module loproc_shift_level
  import loproc_shifter_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHIFT  = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              carry_i,
  input  logic [2:0]        op_i,
  input  logic              en_i,
  input  logic              sign_i,
  output logic [DATA_W-1:0] data_o,
  output logic              carry_o
);

  always_comb begin
    data_o  = data_i;
    carry_o = carry_i;
    if (en_i) begin
      case (op_i)
        SHOP_LSL: begin
          data_o  = data_i << SHIFT;
          carry_o = data_i[DATA_W-SHIFT];
        end
        SHOP_LSR: begin
          data_o  = data_i >> SHIFT;
          carry_o = data_i[SHIFT-1];
        end
        SHOP_ASR: begin
          // Fill comes from the original operand MSB, carried alongside the data.
          data_o  = (data_i >> SHIFT) | ({DATA_W{sign_i}} << (DATA_W - SHIFT));
          carry_o = data_i[SHIFT-1];
        end
        SHOP_ROL: begin
          data_o  = (data_i << SHIFT) | (data_i >> (DATA_W - SHIFT));
          carry_o = data_i[DATA_W-SHIFT];
        end
        SHOP_ROR: begin
          data_o  = (data_i >> SHIFT) | (data_i << (DATA_W - SHIFT));
          carry_o = data_i[SHIFT-1];
        end
        default: begin
          data_o  = data_i;
          carry_o = carry_i;
        end
      endcase
    end
  end

endmodule

// File: rtl/loproc_shifter_pipe.sv
// Pipelined barrel shifter/rotator: SHAMT_W binary levels spread over
// PIPE_STAGES register stages, with valid/ready on both sides.
module loproc_shifter_pipe
  import loproc_shifter_pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SHAMT_W     = DATA_LOG2_DEF,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_carry,
  output logic               out_zero
);

  // Stage registers
  logic [PIPE_STAGES-1:0] valid_d, valid_q;
  logic [DATA_W-1:0]      data_d  [PIPE_STAGES];
  logic [DATA_W-1:0]      data_q  [PIPE_STAGES];
  logic [2:0]             op_d    [PIPE_STAGES];
  logic [2:0]             op_q    [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
  logic                   sign_d  [PIPE_STAGES];
  logic                   sign_q  [PIPE_STAGES];
  logic                   carry_d [PIPE_STAGES];
  logic                   carry_q [PIPE_STAGES];
  logic                   zero_d, zero_q;

  // Per-stage inputs (from the port or the previous register) and level outputs
  logic                   src_valid [PIPE_STAGES];
  logic [DATA_W-1:0]      src_data  [PIPE_STAGES];
  logic [2:0]             src_op    [PIPE_STAGES];
  logic [SHAMT_W-1:0]     src_shamt [PIPE_STAGES];
  logic                   src_sign  [PIPE_STAGES];
  logic                   src_carry [PIPE_STAGES];
  logic [DATA_W-1:0]      res_data  [PIPE_STAGES];
  logic                   res_carry [PIPE_STAGES];

  logic [DATA_W-1:0]      lvl_din   [SHAMT_W];
  logic                   lvl_cin   [SHAMT_W];
  logic [DATA_W-1:0]      lvl_dout  [SHAMT_W];
  logic                   lvl_cout  [SHAMT_W];

  logic [PIPE_STAGES:0]   ready;

  // Handshake: a beat transfers on a rising edge where valid && ready. A stage
  // may load when it is empty or its successor takes its content this cycle, so
  // ready ripples back combinationally from out_ready with no bubble cycles.
  always_comb begin
    ready              = '0;
    ready[PIPE_STAGES] = out_ready;
    for (int g = PIPE_STAGES - 1; g >= 0; g--) begin
      ready[g] = !valid_q[g] || ready[g+1];
    end
  end

  assign in_ready = rstn && ready[0];

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_op[0]    = in_op;
    src_shamt[0] = in_shamt;
    src_sign[0]  = in_data[DATA_W-1];
    src_carry[0] = 1'b0;
    for (int g = 1; g < PIPE_STAGES; g++) begin
      src_valid[g] = valid_q[g-1];
      src_data[g]  = data_q[g-1];
      src_op[g]    = op_q[g-1];
      src_shamt[g] = shamt_q[g-1];
      src_sign[g]  = sign_q[g-1];
      src_carry[g] = carry_q[g-1];
    end
  end

  for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
    localparam int STG   = stage_of(j, SHAMT_W, PIPE_STAGES);
    localparam int FIRST = lvl_first(STG, SHAMT_W, PIPE_STAGES);
    localparam int LAST  = FIRST + lvl_count(STG, SHAMT_W, PIPE_STAGES) - 1;

    if (j == FIRST) begin : g_head
      assign lvl_din[j] = src_data[STG];
      assign lvl_cin[j] = src_carry[STG];
    end else begin : g_chain
      assign lvl_din[j] = lvl_dout[j-1];
      assign lvl_cin[j] = lvl_cout[j-1];
    end

    loproc_shift_level #(
      .DATA_W (DATA_W),
      .SHIFT  (1 << j)
    ) u_level (
      .data_i  (lvl_din[j]),
      .carry_i (lvl_cin[j]),
      .op_i    (src_op[STG]),
      .en_i    (src_shamt[STG][j]),
      .sign_i  (src_sign[STG]),
      .data_o  (lvl_dout[j]),
      .carry_o (lvl_cout[j])
    );

    if (j == LAST) begin : g_tail
      assign res_data[STG]  = lvl_dout[j];
      assign res_carry[STG] = lvl_cout[j];
    end
  end

  // A stage only loads when it may advance, so a stalled stage holds everything.
  always_comb begin
    valid_d = valid_q;
    zero_d  = zero_q;
    for (int g = 0; g < PIPE_STAGES; g++) begin
      data_d[g]  = data_q[g];
      op_d[g]    = op_q[g];
      shamt_d[g] = shamt_q[g];
      sign_d[g]  = sign_q[g];
      carry_d[g] = carry_q[g];
      if (ready[g]) begin
        valid_d[g] = src_valid[g];
        if (src_valid[g]) begin
          data_d[g]  = res_data[g];
          op_d[g]    = src_op[g];
          shamt_d[g] = src_shamt[g];
          sign_d[g]  = src_sign[g];
          carry_d[g] = res_carry[g];
        end
      end
    end
    if (ready[PIPE_STAGES-1] && src_valid[PIPE_STAGES-1]) begin
      zero_d = (res_data[PIPE_STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= '0;
      zero_q  <= 1'b0;
      for (int g = 0; g < PIPE_STAGES; g++) begin
        data_q[g]  <= '0;
        op_q[g]    <= '0;
        shamt_q[g] <= '0;
        sign_q[g]  <= 1'b0;
        carry_q[g] <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      zero_q  <= zero_d;
      for (int g = 0; g < PIPE_STAGES; g++) begin
        data_q[g]  <= data_d[g];
        op_q[g]    <= op_d[g];
        shamt_q[g] <= shamt_d[g];
        sign_q[g]  <= sign_d[g];
        carry_q[g] <= carry_d[g];
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_carry = carry_q[PIPE_STAGES-1];
  assign out_zero  = zero_q;

endmodule
